// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control path:
// FSM states, opcodes, ALU operations and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BZ   = 4'b1001;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOT1  = 3'b100;
    localparam logic [2:0] ALU_PASS1 = 3'b101;
    localparam logic [2:0] ALU_PASS2 = 3'b110;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    // R-type opcodes occupy 0000..0101 and carry their ALU op in the low bits
    function automatic logic is_rtype(input logic [3:0] op);
        return (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath (slave): status inputs in, selects and strobes out.
interface multicycle_controller_if #(parameter int OPW = 4);

    logic [OPW-1:0] Opcode;
    logic           Zero;
    logic           MemReady;
    logic           MemRead;
    logic           MemWrite;
    logic           IorD;
    logic           IRWrite;
    logic           PCWrite;
    logic [1:0]     PCSrc;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [2:0]     ALUControl;
    logic           RegWrite;
    logic           MemToReg;
    logic           RegDst;
    logic           Halted;
    logic [3:0]     State;

    modport master (
        input  Opcode, Zero, MemReady,
        output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, MemToReg,
               RegDst, Halted, State
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
               ALUSrcA, ALUSrcB, ALUControl, RegWrite, MemToReg,
               RegDst, Halted, State
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Selects the ALU operation from the controller state; R-type execute
// forwards the opcode's low bits, branch compares by subtraction.
module alu_op_decoder
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] rtype_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (state)
            S_EXEC_R: alu_control = rtype_op;
            S_BRANCH: alu_control = ALU_SUB;
            default:  alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the 16-bit multicycle CPU: sequences fetch, decode,
// execute, memory and writeback, driving every datapath select and strobe.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_controller_if.master bus
);

    state_t     state;
    state_t     next_state;
    logic [3:0] op;
    logic [2:0] alu_control;

    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       halted;

    assign op = bus.Opcode[OPW-1:OPW-4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (bus.MemReady) next_state = S_DECODE;
            S_DECODE: begin
                if (is_rtype(op))                   next_state = S_EXEC_R;
                else if (op == OP_ADDI)             next_state = S_EXEC_I;
                else if (op == OP_LW || op == OP_SW) next_state = S_MEM_ADDR;
                else if (op == OP_BZ)               next_state = S_BRANCH;
                else if (op == OP_JMP)              next_state = S_JUMP;
                else if (op == OP_HALT)             next_state = S_HALT;
                else                                next_state = S_FETCH;
            end
            S_EXEC_R:   next_state = S_WB_R;
            S_WB_R:     next_state = S_FETCH;
            S_EXEC_I:   next_state = S_WB_I;
            S_WB_I:     next_state = S_FETCH;
            S_MEM_ADDR: next_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.MemReady) next_state = S_WB_MEM;
            S_WB_MEM:   next_state = S_FETCH;
            S_MEM_WR:   if (bus.MemReady) next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JUMP:     next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_IDLE;
        endcase
    end

    // Moore decode; only the PC/IR load strobes look at live inputs
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = bus.MemReady;
                pc_write  = bus.MemReady;
            end
            S_DECODE: alu_src_b = SRCB_IMM;
            S_EXEC_R: alu_src_a = 1'b1;
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_WB_I: reg_write = 1'b1;
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = bus.Zero;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    alu_op_decoder u_alu_op_decoder (
        .state       (state),
        .rtype_op    (op[2:0]),
        .alu_control (alu_control)
    );

    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.IorD       = iord;
    assign bus.IRWrite    = ir_write;
    assign bus.PCWrite    = pc_write;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.RegWrite   = reg_write;
    assign bus.MemToReg   = mem_to_reg;
    assign bus.RegDst     = reg_dst;
    assign bus.Halted     = halted;
    assign bus.State      = state;

endmodule
